// File: rtl/tdm_demux_1x8_if.sv
// Serial-link bundle between the TDM demux and its sample source.
// parity_err exists only when TDM_DEMUX_PARITY_EN is defined.
interface tdm_demux_1x8_if;
  logic       en;
  logic       sync;
  logic       din;
  logic [3:0] sel;
  logic [7:0] q;
  logic       frame_valid;
  logic       locked;
  logic       resync;
`ifdef TDM_DEMUX_PARITY_EN
  logic       parity_err;
`endif

  // Source side: drives samples, receives selects and frames.
  modport master (
    output en, sync, din,
`ifdef TDM_DEMUX_PARITY_EN
    input  parity_err,
`endif
    input  sel, q, frame_valid, locked, resync
  );

  // Demux side.
  modport slave (
    input  en, sync, din,
`ifdef TDM_DEMUX_PARITY_EN
    output parity_err,
`endif
    output sel, q, frame_valid, locked, resync
  );
endinterface

// File: rtl/tdm_demux_1x8.sv
// 1-bit to 8-bit TDM demultiplexer: drives mux selects, rebuilds frames, flags resyncs.
// Optional TDM_DEMUX_PARITY_EN adds a ninth even-parity slot and parity_err.
module tdm_demux_1x8 #(
  parameter int unsigned SLOTS = 8
) (
  input  logic            clk,
  input  logic            rst,
  tdm_demux_1x8_if.slave  bus
);

  localparam int unsigned SLOT_W = 4;
  localparam int unsigned DATA_W = 8;
`ifdef TDM_DEMUX_PARITY_EN
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(8);
`else
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(7);
`endif

  if (SLOTS != 8) begin : g_bad_slots
    $error("tdm_demux_1x8 supports exactly 8 data slots");
  end

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [SLOT_W-1:0]   slot;
  logic [SLOT_W-1:0]   slot_nxt;
  logic [DATA_W-1:0]   shreg;
  logic [DATA_W-1:0]   shreg_nxt;
  logic [DATA_W-1:0]   q_r;
  logic [DATA_W-1:0]   q_nxt;
  logic                fv_r;
  logic                fv_nxt;
  logic                rs_r;
  logic                rs_nxt;
  logic                locked_r;
`ifdef TDM_DEMUX_PARITY_EN
  logic                pe_r;
  logic                pe_nxt;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: alignment is only gained from IDLE on a sync sample; only reset leaves RUN.
  always_comb begin
    state_nxt = state;
    if (state == IDLE && bus.en && bus.sync) state_nxt = RUN;
  end

  // Datapath next values.
  always_comb begin
    slot_nxt  = slot;
    shreg_nxt = shreg;
    q_nxt     = q_r;
    fv_nxt    = 1'b0;
    rs_nxt    = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    pe_nxt    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (bus.en && bus.sync) begin
          shreg_nxt[0] = bus.din;
          slot_nxt     = SLOT_W'(1);
        end
      end
      RUN: begin
        if (bus.en) begin
          if (bus.sync && slot != '0) begin
            // Sync mid-frame: drop the partial frame and restart at slot 1.
            shreg_nxt = {{(DATA_W-1){1'b0}}, bus.din};
            slot_nxt  = SLOT_W'(1);
            rs_nxt    = 1'b1;
          end else if (slot == LAST_SLOT) begin
`ifdef TDM_DEMUX_PARITY_EN
            q_nxt  = shreg;
            pe_nxt = bus.din ^ (^shreg);
`else
            q_nxt  = {bus.din, shreg[DATA_W-2:0]};
`endif
            fv_nxt   = 1'b1;
            slot_nxt = '0;
          end else begin
            shreg_nxt[slot[2:0]] = bus.din;
            slot_nxt             = slot + SLOT_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot     <= '0;
      shreg    <= '0;
      q_r      <= '0;
      fv_r     <= 1'b0;
      rs_r     <= 1'b0;
      locked_r <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      pe_r     <= 1'b0;
`endif
    end else begin
      slot     <= slot_nxt;
      shreg    <= shreg_nxt;
      q_r      <= q_nxt;
      fv_r     <= fv_nxt;
      rs_r     <= rs_nxt;
      locked_r <= (state_nxt == RUN);
`ifdef TDM_DEMUX_PARITY_EN
      pe_r     <= pe_nxt;
`endif
    end
  end

  // slot is held at 0 while IDLE, so it doubles as the select output.
  assign bus.sel         = slot;
  assign bus.q           = q_r;
  assign bus.frame_valid = fv_r;
  assign bus.resync      = rs_r;
  assign bus.locked      = locked_r;
`ifdef TDM_DEMUX_PARITY_EN
  assign bus.parity_err  = pe_r;
`endif

endmodule

// File: tb/tb_tdm_demux_1x8.sv
// Directed self-checking bench for tdm_demux_1x8 (both default and TDM_DEMUX_PARITY_EN builds).
module tb_tdm_demux_1x8;

`ifdef TDM_DEMUX_PARITY_EN
  localparam int N = 9;
`else
  localparam int N = 8;
`endif

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   fv_cnt = 0;
  int   rs_cnt = 0;
  int   cyc    = 0;

  tdm_demux_1x8_if bus ();

  tdm_demux_1x8 #(.SLOTS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs, then look at outputs 1ns after the edge.
  task automatic tick(input logic e, input logic s, input logic d, input logic r);
    @(negedge clk);
    bus.en   = e;
    bus.sync = s;
    bus.din  = d;
    rst      = r;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.frame_valid) fv_cnt++;
    if (bus.resync)      rs_cnt++;
  endtask

  // Slot i of a frame; slot 8 is the even-parity bit, optionally corrupted.
  function automatic logic fbit(input logic [7:0] d, input int i, input logic bad);
    if (i < 8) return d[i];
    return (^d) ^ bad;
  endfunction

  task automatic test_reset();
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (bus.q !== 8'h00) begin errors++; $display("FAIL reset_q got=%h exp=00", bus.q); end
    checks++; if (bus.sel !== 4'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", bus.sel); end
    checks++; if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got=%b exp=0", bus.frame_valid); end
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%b exp=0", bus.locked); end
    checks++; if (bus.resync !== 1'b0) begin errors++; $display("FAIL reset_resync got=%b exp=0", bus.resync); end
`ifdef TDM_DEMUX_PARITY_EN
    checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr got=%b exp=0", bus.parity_err); end
`endif
  endtask

  task automatic test_basic_frame();
    fv_cnt = 0;
    for (int i = 0; i < N; i++) begin
      tick(1'b1, i == 0, fbit(8'b00110010, i, 1'b0), 1'b0);
      checks++;
      if (bus.sel !== 4'((i + 1) % N)) begin
        errors++; $display("FAIL basic_sel slot=%0d got=%0d exp=%0d", i, bus.sel, (i + 1) % N);
      end
      checks++;
      if (bus.frame_valid !== (i == N - 1)) begin
        errors++; $display("FAIL basic_fv slot=%0d got=%b", i, bus.frame_valid);
      end
    end
    checks++; if (bus.q !== 8'h32) begin errors++; $display("FAIL basic_q got=%h exp=32", bus.q); end
    checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL basic_locked got=%b exp=1", bus.locked); end
    checks++; if (fv_cnt != 1) begin errors++; $display("FAIL basic_fv_count got=%0d exp=1", fv_cnt); end
`ifdef TDM_DEMUX_PARITY_EN
    checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL basic_perr got=%b exp=0", bus.parity_err); end
`endif
  endtask

  task automatic test_en_toggle();
    fv_cnt = 0;
    for (int i = 0; i < N; i++) begin
      tick(1'b1, i == 0, fbit(8'b00110010, i, 1'b0), 1'b0);
      checks++;
      if (bus.frame_valid !== (i == N - 1)) begin
        errors++; $display("FAIL toggle_fv enabled_edge=%0d got=%b", i + 1, bus.frame_valid);
      end
      tick(1'b0, 1'b1, ~fbit(8'b00110010, i, 1'b0), 1'b0);
      checks++;
      if (bus.sel !== 4'((i + 1) % N)) begin
        errors++; $display("FAIL toggle_sel_hold slot=%0d got=%0d exp=%0d", i, bus.sel, (i + 1) % N);
      end
      checks++;
      if (bus.frame_valid !== 1'b0) begin
        errors++; $display("FAIL toggle_fv_idle slot=%0d got=%b exp=0", i, bus.frame_valid);
      end
    end
    checks++; if (bus.q !== 8'h32) begin errors++; $display("FAIL toggle_q got=%h exp=32", bus.q); end
    checks++; if (fv_cnt != 1) begin errors++; $display("FAIL toggle_fv_count got=%0d exp=1", fv_cnt); end
  endtask

  task automatic test_resync();
    fv_cnt = 0;
    rs_cnt = 0;
    for (int i = 0; i < 5; i++) tick(1'b1, i == 0, fbit(8'hA5, i, 1'b0), 1'b0);
    checks++; if (bus.sel !== 4'd5) begin errors++; $display("FAIL resync_presel got=%0d exp=5", bus.sel); end
    for (int i = 0; i < N; i++) begin
      tick(1'b1, i == 0, fbit(8'h3C, i, 1'b0), 1'b0);
      if (i == 0) begin
        checks++; if (bus.resync !== 1'b1) begin errors++; $display("FAIL resync_pulse got=%b exp=1", bus.resync); end
        checks++; if (bus.sel !== 4'd1) begin errors++; $display("FAIL resync_sel got=%0d exp=1", bus.sel); end
        checks++; if (bus.q !== 8'h32) begin errors++; $display("FAIL resync_q_hold got=%h exp=32", bus.q); end
      end
    end
    checks++; if (rs_cnt != 1) begin errors++; $display("FAIL resync_count got=%0d exp=1", rs_cnt); end
    checks++; if (fv_cnt != 1) begin errors++; $display("FAIL resync_fv_count got=%0d exp=1", fv_cnt); end
    checks++; if (bus.q !== 8'h3C) begin errors++; $display("FAIL resync_q got=%h exp=3c", bus.q); end
  endtask

  task automatic test_mid_reset();
    fv_cnt = 0;
    rs_cnt = 0;
    for (int i = 0; i < 4; i++) tick(1'b1, i == 0, fbit(8'h55, i, 1'b0), 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    checks++; if (bus.q !== 8'h00) begin errors++; $display("FAIL midrst_q got=%h exp=00", bus.q); end
    checks++; if (bus.sel !== 4'd0) begin errors++; $display("FAIL midrst_sel got=%0d exp=0", bus.sel); end
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL midrst_locked got=%b exp=0", bus.locked); end
    checks++; if (bus.frame_valid !== 1'b0 || bus.resync !== 1'b0) begin
      errors++; $display("FAIL midrst_pulses fv=%b resync=%b exp=0", bus.frame_valid, bus.resync);
    end
    for (int i = 0; i < N; i++) tick(1'b1, 1'b0, 1'b1, 1'b0);
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL nosync_locked got=%b exp=0", bus.locked); end
    checks++; if (bus.q !== 8'h00) begin errors++; $display("FAIL nosync_q got=%h exp=00", bus.q); end
    checks++; if (bus.sel !== 4'd0) begin errors++; $display("FAIL nosync_sel got=%0d exp=0", bus.sel); end
    checks++; if (fv_cnt != 0 || rs_cnt != 0) begin
      errors++; $display("FAIL nosync_pulses fv=%0d resync=%0d exp=0", fv_cnt, rs_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int         hits = 0;
    int         t0   = 0;
    int         t1   = 0;
    logic [7:0] q0   = 8'h00;
    logic [7:0] q1   = 8'h00;
    for (int k = 0; k < 2 * N; k++) begin
      tick(1'b1, k == 0, fbit((k < N) ? 8'h12 : 8'h34, k % N, 1'b0), 1'b0);
      if (bus.frame_valid === 1'b1) begin
        if (hits == 0) begin t0 = cyc; q0 = bus.q; end
        else           begin t1 = cyc; q1 = bus.q; end
        hits++;
      end
    end
    checks++; if (hits != 2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", hits); end
    checks++; if (q0 !== 8'h12) begin errors++; $display("FAIL b2b_q0 got=%h exp=12", q0); end
    checks++; if (q1 !== 8'h34) begin errors++; $display("FAIL b2b_q1 got=%h exp=34", q1); end
    checks++; if (t1 - t0 != N) begin errors++; $display("FAIL b2b_spacing got=%0d exp=%0d", t1 - t0, N); end
  endtask

`ifdef TDM_DEMUX_PARITY_EN
  task automatic test_parity();
    for (int i = 0; i < N; i++) tick(1'b1, i == 0, (i < 8) ? fbit(8'h07, i, 1'b0) : 1'b1, 1'b0);
    checks++; if (bus.frame_valid !== 1'b1 || bus.parity_err !== 1'b0) begin
      errors++; $display("FAIL par_good fv=%b perr=%b exp fv=1 perr=0", bus.frame_valid, bus.parity_err);
    end
    checks++; if (bus.q !== 8'h07) begin errors++; $display("FAIL par_good_q got=%h exp=07", bus.q); end
    for (int i = 0; i < N; i++) tick(1'b1, i == 0, (i < 8) ? fbit(8'h07, i, 1'b0) : 1'b0, 1'b0);
    checks++; if (bus.frame_valid !== 1'b1 || bus.parity_err !== 1'b1) begin
      errors++; $display("FAIL par_bad fv=%b perr=%b exp fv=1 perr=1", bus.frame_valid, bus.parity_err);
    end
    checks++; if (bus.q !== 8'h07) begin errors++; $display("FAIL par_bad_q got=%h exp=07", bus.q); end
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL par_pulse got=%b exp=0", bus.parity_err); end
  endtask
`endif

  initial begin
    bus.en   = 1'b0;
    bus.sync = 1'b0;
    bus.din  = 1'b0;
    rst      = 1'b1;
    test_reset();
    test_basic_frame();
    test_en_toggle();
    test_resync();
    test_mid_reset();
    test_back_to_back();
`ifdef TDM_DEMUX_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tdm_demux_1x8.md
# tdm_demux_1x8

Time-division demultiplexer that rebuilds an 8-bit parallel word from a 1-bit serial stream produced by the team's 8:1 mux scanning its select lines 0..7. It sits at the receive end of that serial link. It generates the slot index (`sel`) that drives the upstream mux selects, captures one bit per enabled clock, and presents each completed frame on `q` with a one-cycle valid pulse.

## Interface
- `SLOTS`, default 8: data slots per frame. Fixed at 8; the parameter is for documentation and assertions only.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: sample strobe; `din`/`sync` are only looked at when `en`=1.
- `sync` in 1: frame start; with `en`=1, the current `din` is slot 0.
- `din` in 1: serial data bit (mux `out`).
- `sel` out 4: slot index of the next expected sample; `sel[2:0]` drives mux s2..s0, `sel[3]` is used only for the parity slot.
- `q` out 8: last complete frame, `q[i]` = slot-i bit.
- `frame_valid` out 1: one-cycle pulse when `q` updates.
- `locked` out 1: 1 while in RUN.
- `resync` out 1: one-cycle pulse when `sync` aborts a partial frame.
- `parity_err` out 1: present only with `TDM_DEMUX_PARITY_EN`.

## Operation
- States:
  - IDLE: unaligned, reset state.
  - RUN: aligned.
- Internal registers:
  - `slot` (4 b), the counter.
  - `shreg[7:0]`, the partial frame.
- IDLE:
  - `en`&`sync`: `shreg[0]`<=`din`, `slot`<=1, go to RUN.
  - `en`&!`sync`: ignored.
  - `en`=0: no change.
- RUN, `en`&!`sync`: `shreg[slot]`<=`din`, then `slot`++.
  - When the sampled slot is the last one (7, or 8 with parity), do not write `shreg[slot]`. Instead:
    - load `q`<={`din`,`shreg[6:0]`}, or `shreg` with parity;
    - pulse `frame_valid`;
    - set `slot`<=0 and stay in RUN.
- RUN, `en`&`sync`:
  - `slot`==0: normal slot-0 sample; `sync` is legal at every frame start.
  - `slot`!=0: discard the partial frame, `shreg[0]`<=`din`, `slot`<=1, pulse `resync`. No `frame_valid`; `q` holds.
- RUN, `en`=0: all state holds; `sel` holds.
- `sel` = `slot` in RUN, 0 in IDLE.
- `locked` = (state==RUN).
- `q` changes only on frame completion or reset.

## Timing
- Reset values: `q`=8'h00, `sel`=0, `frame_valid`=0, `locked`=0, `resync`=0, `parity_err`=0, state IDLE, `slot`=0, `shreg`=0.
- `rst` overrides `en`/`sync` in the same cycle. A mid-frame reset drops the partial frame without any pulse.
- All outputs are registered.
- `q`/`frame_valid`/`parity_err` update on the edge that samples the last slot and are visible in the following cycle.
- Frame latency: from the edge that samples slot 0 to `frame_valid` high is N enabled edges (N = 8, or 9 with parity); idle `en`=0 cycles stretch it.
- `sel` is updated on the same edge as the sample, so the mux select for the next slot is ready one cycle ahead of the next `en`.
- `slot` wraps to 0 after the last slot, never beyond it.
- With back-to-back frames and `en` held high, `frame_valid` pulses every N cycles.

## Configuration
- `TDM_DEMUX_PARITY_EN` defined:
  - Frame = 9 slots; slot 8 (`sel`=4'd8) carries even parity over slots 0..7.
  - At slot-8 completion, `q`<=`shreg` and `frame_valid` pulses.
  - `parity_err` pulses with `frame_valid` iff `din` != ^`shreg`.
  - `q` still updates on a parity mismatch.
- Undefined: 8 slots, `sel[3]` tied 0, no `parity_err` port.

## Test plan
- Reset, then `en`=1 with `sync` on the first sample and `din` sequence 0,1,0,0,1,1,0,0 (slots 0..7): `frame_valid` pulses once, `q`=8'b00110010, `locked`=1, `sel` steps 1..7 then 0.
- `en` toggled 1,0 per cycle across the same frame: identical `q`; `frame_valid` arrives after 8 enabled edges; `sel` holds during `en`=0.
- `sync` asserted at `slot`=5 during frame 8'hA5, followed by 8 slots of 8'h3C: `resync` pulses once, no `frame_valid` for the aborted frame, next `q`=8'h3C.
- `rst` asserted at `slot`=4: all outputs are at reset values the next cycle; a following 8'hFF frame without a leading `sync` is ignored (`locked`=0, `q`=8'h00).
- Two back-to-back frames 8'h12 then 8'h34 with `sync` only on the first: `frame_valid` pulses 8 cycles apart, `q`=8'h12 then 8'h34.
- With `TDM_DEMUX_PARITY_EN`: frame 8'h07 with parity 1 gives `parity_err`=0; the same frame with parity 0 gives `parity_err`=1 with `frame_valid`, and `q`=8'h07 in both cases.
